// File: rtl/ex_wb_sequencer.sv
// ex_wb_sequencer: turns ALU results into register-file write strobes.
// Ordinary results produce one registered write. A SWAP produces two writes
// on back-to-back cycles (low half first, then high half) and stalls
// upstream for one cycle. Overflow on ADD/SUB suppresses the write and
// raises a sticky exception that records the offending destination.
module ex_wb_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic                  alu_overflow,
    input  logic [2:0]            alu_op,
    input  logic                  reg_write,
    input  logic [ADDR_W-1:0]     rd_lo,
    input  logic [ADDR_W-1:0]     rd_hi,
    input  logic                  flush,
    input  logic                  exc_clear,
    output logic                  wb_en,
    output logic [ADDR_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  exc,
    output logic [ADDR_W-1:0]     exc_rd
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SWAP = 3'b011;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic                  wb_en_reg, wb_en_next;
    logic [ADDR_W-1:0]     wb_addr_reg, wb_addr_next;
    logic [DATA_W-1:0]     wb_data_reg, wb_data_next;
    logic                  exc_reg, exc_next;
    logic [ADDR_W-1:0]     exc_rd_reg, exc_rd_next;
    logic [ADDR_W-1:0]     hi_addr_reg, hi_addr_next;
    logic [DATA_W-1:0]     hi_data_reg, hi_data_next;

    logic                  accept;
    logic                  arith_op;
    logic                  ovf_hit;

    // Upstream may only hand over a result while no second write is pending.
    assign in_ready = (state_reg == IDLE);
    assign wb_en    = wb_en_reg;
    assign wb_addr  = wb_addr_reg;
    assign wb_data  = wb_data_reg;
    assign exc      = exc_reg;
    assign exc_rd   = exc_rd_reg;

    // Handshake qualification; overflow only counts for writing ADD/SUB results.
    always_comb begin
        accept   = in_valid & in_ready & ~flush;
        arith_op = (alu_op == OP_ADD) || (alu_op == OP_SUB);
        ovf_hit  = accept & reg_write & alu_overflow & arith_op;
    end

    // Next-state, write strobe, SWAP buffer and sticky exception.
    always_comb begin
        state_next   = state_reg;
        wb_en_next   = 1'b0;
        wb_addr_next = wb_addr_reg;
        wb_data_next = wb_data_reg;
        exc_next     = exc_reg;
        exc_rd_next  = exc_rd_reg;
        hi_addr_next = hi_addr_reg;
        hi_data_next = hi_data_reg;

        // A new overflow wins over a simultaneous clear.
        if (exc_clear) begin
            exc_next = 1'b0;
        end
        if (ovf_hit) begin
            exc_next    = 1'b1;
            exc_rd_next = rd_lo;
        end

        case (state_reg)
            IDLE: begin
                if (accept && reg_write && !ovf_hit) begin
                    wb_en_next   = 1'b1;
                    wb_addr_next = rd_lo;
                    wb_data_next = alu_result[DATA_W-1:0];
                    if (alu_op == OP_SWAP) begin
                        state_next   = SECOND;
                        hi_addr_next = rd_hi;
                        hi_data_next = alu_result[2*DATA_W-1:DATA_W];
                    end
                end
            end
            SECOND: begin
                // Flush here cancels the pending high-half write.
                state_next = IDLE;
                if (!flush) begin
                    wb_en_next   = 1'b1;
                    wb_addr_next = hi_addr_reg;
                    wb_data_next = hi_data_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            wb_en_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
            exc_reg     <= 1'b0;
            exc_rd_reg  <= '0;
            hi_addr_reg <= '0;
            hi_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wb_en_reg   <= wb_en_next;
            wb_addr_reg <= wb_addr_next;
            wb_data_reg <= wb_data_next;
            exc_reg     <= exc_next;
            exc_rd_reg  <= exc_rd_next;
            hi_addr_reg <= hi_addr_next;
            hi_data_reg <= hi_data_next;
        end
    end

endmodule
